// File: rtl/cpu7_exu_byp_scoreboard_pkg.sv
// Shared constants for the cpu7 EXU bypass/hazard unit: default widths and the
// one-hot operand-origin encodings used by the per-source select logic.
package cpu7_exu_byp_scoreboard_pkg;

    localparam int REG_AW_DEF  = 5;
    localparam int MAX_LNG_DEF = 4;

    typedef logic [2:0] byp_sel_t;

    localparam byp_sel_t BYP_SEL_RF = 3'b001;
    localparam byp_sel_t BYP_SEL_M  = 3'b010;
    localparam byp_sel_t BYP_SEL_W  = 3'b100;

endpackage

// File: rtl/cpu7_exu_byp_scoreboard_if.sv
// E-stage operand/hazard bundle between the pipeline (master) and the bypass unit
// (slave). Carries source/writer indices in and selects, stall and scoreboard out.
interface cpu7_exu_byp_scoreboard_if
    import cpu7_exu_byp_scoreboard_pkg::*;
#(
    parameter int NUM_RS = 2,
    parameter int REG_AW = REG_AW_DEF
);
    logic [NUM_RS*REG_AW-1:0] rs_e;
    logic [NUM_RS-1:0]        rs_vld_e;
    logic [REG_AW-1:0]        rd_e;
    logic                     lng_issue_e;
    logic [REG_AW-1:0]        rd_m;
    logic                     wen_m;
    logic                     ld_m;
    logic [REG_AW-1:0]        rd_w;
    logic                     wen_w;
    logic                     lng_wb_w;
    logic                     flush;
    logic [NUM_RS-1:0]        sel_rf;
    logic [NUM_RS-1:0]        sel_m;
    logic [NUM_RS-1:0]        sel_w;
    logic                     stall_e;
    logic [(1<<REG_AW)-1:0]   lng_pend;
    logic [31:0]              stall_cnt;

    modport master (
        output rs_e, rs_vld_e, rd_e, lng_issue_e, rd_m, wen_m, ld_m,
               rd_w, wen_w, lng_wb_w, flush,
        input  sel_rf, sel_m, sel_w, stall_e, lng_pend, stall_cnt
    );

    modport slave (
        input  rs_e, rs_vld_e, rd_e, lng_issue_e, rd_m, wen_m, ld_m,
               rd_w, wen_w, lng_wb_w, flush,
        output sel_rf, sel_m, sel_w, stall_e, lng_pend, stall_cnt
    );
endinterface

// File: rtl/cpu7_exu_byp_srcsel.sv
// Per-source operand origin select (M beats W beats regfile) plus this source's
// load-use and pending-long-op hazard terms. Purely combinational.
module cpu7_exu_byp_srcsel
    import cpu7_exu_byp_scoreboard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0]      rs_i,
    input  logic                   rs_vld_i,
    input  logic [REG_AW-1:0]      rd_m_i,
    input  logic                   wen_m_i,
    input  logic                   ld_m_i,
    input  logic [REG_AW-1:0]      rd_w_i,
    input  logic                   wen_w_i,
    input  logic                   lng_wb_w_i,
    input  logic [(1<<REG_AW)-1:0] lng_pend_i,
    output logic                   sel_rf_o,
    output logic                   sel_m_o,
    output logic                   sel_w_o,
    output logic                   lduse_o,
    output logic                   pend_o
);
    logic     nz;
    logic     m_hit;
    logic     w_hit;
    logic     wb_now;
    byp_sel_t sel;

    assign nz    = (rs_i != '0);
    assign m_hit = nz & wen_m_i & (rd_m_i == rs_i);
    assign w_hit = nz & wen_w_i & (rd_w_i == rs_i) & ~m_hit;
    assign sel   = m_hit ? BYP_SEL_M : (w_hit ? BYP_SEL_W : BYP_SEL_RF);

    assign sel_rf_o = (sel == BYP_SEL_RF);
    assign sel_m_o  = (sel == BYP_SEL_M);
    assign sel_w_o  = (sel == BYP_SEL_W);

    // A long op returning this very cycle is forwarded from W, so it is not a hazard.
    assign wb_now  = wen_w_i & lng_wb_w_i & (rd_w_i == rs_i);
    assign lduse_o = rs_vld_i & m_hit & ld_m_i;
    assign pend_o  = rs_vld_i & nz & lng_pend_i[rs_i] & ~wb_now;
endmodule

// File: rtl/cpu7_exu_byp_scoreboard.sv
// cpu7 EXU operand bypass and hazard unit: selects/stall are combinational, the
// long-op scoreboard and outstanding count update on clk. CPU7_BYP_STALL_CNT_EN adds a stall counter.
module cpu7_exu_byp_scoreboard
    import cpu7_exu_byp_scoreboard_pkg::*;
#(
    parameter int NUM_RS  = 2,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MAX_LNG = MAX_LNG_DEF,
    parameter int CNT_W   = 3
) (
    input  logic                      clk,
    input  logic                      resetn,
    cpu7_exu_byp_scoreboard_if.slave  bus
);
    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0]   lng_pend_q, lng_pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_RS-1:0] lduse_v;
    logic [NUM_RS-1:0] pend_v;
    logic              waw;
    logic              full;
    logic              stall;
    logic              iss;
    logic              clr;

    for (genvar g = 0; g < NUM_RS; g++) begin : g_src
        cpu7_exu_byp_srcsel #(.REG_AW(REG_AW)) u_srcsel (
            .rs_i       (bus.rs_e[g*REG_AW +: REG_AW]),
            .rs_vld_i   (bus.rs_vld_e[g]),
            .rd_m_i     (bus.rd_m),
            .wen_m_i    (bus.wen_m),
            .ld_m_i     (bus.ld_m),
            .rd_w_i     (bus.rd_w),
            .wen_w_i    (bus.wen_w),
            .lng_wb_w_i (bus.lng_wb_w),
            .lng_pend_i (lng_pend_q),
            .sel_rf_o   (bus.sel_rf[g]),
            .sel_m_o    (bus.sel_m[g]),
            .sel_w_o    (bus.sel_w[g]),
            .lduse_o    (lduse_v[g]),
            .pend_o     (pend_v[g])
        );
    end

    assign waw   = bus.lng_issue_e & (bus.rd_e != '0) & lng_pend_q[bus.rd_e];
    assign full  = bus.lng_issue_e & (cnt_q == CNT_W'(MAX_LNG));
    assign stall = (|lduse_v) | (|pend_v) | waw | full;
    assign iss   = bus.lng_issue_e & ~stall & ~bus.flush & (bus.rd_e != '0);
    assign clr   = bus.wen_w & bus.lng_wb_w;

    // Set is applied after clear so a newer issue to the same register survives.
    always_comb begin
        lng_pend_d = lng_pend_q;
        cnt_d      = cnt_q;
        if (clr) lng_pend_d[bus.rd_w] = 1'b0;
        if (iss) lng_pend_d[bus.rd_e] = 1'b1;
        if (iss && !clr)
            cnt_d = cnt_q + CNT_W'(1);
        else if (clr && !iss && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
        if (bus.flush) begin
            lng_pend_d = '0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lng_pend_q <= '0;
            cnt_q      <= '0;
        end else begin
            lng_pend_q <= lng_pend_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.stall_e  = stall;
    assign bus.lng_pend = lng_pend_q;

`ifdef CPU7_BYP_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stall_cnt_q <= '0;
        else if (stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 32'd0;
`endif

`ifndef SYNTHESIS
    // Writebacks with nothing outstanding are only legal as stragglers of a flush.
    logic wb_stale_ok_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_stale_ok_q <= 1'b0;
        end else begin
            if (bus.flush) wb_stale_ok_q <= 1'b1;
            if (clr && !iss && !bus.flush && cnt_q == '0)
                assert (wb_stale_ok_q)
                else $error("long-op writeback with no outstanding long op");
        end
    end
`endif
endmodule
